// File: rtl/example_mul_share_arb.sv
// Round-robin shared signed multiplier: NUM_REQ requesters, MUL_STAGES-deep product pipe, FWFT result FIFO.
// Define EXAMPLE_MUL_SAT_EN to saturate the product to the signed P_W range instead of wrapping.
module example_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int A_W        = 12,
  parameter int B_W        = 14,
  parameter int P_W        = 21,
  parameter int MUL_STAGES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_W-1:0]     req_a,
  input  logic [NUM_REQ*B_W-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_W-1:0]             rsp_p,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int FULL_W = A_W + B_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             issue_ok;
  logic             issue;
  logic             pop;
  logic [CNT_W-1:0] credit_cnt;
  int               cand;

  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [ID_W-1:0]  s1_id;
  logic             s1_v;

  logic signed [FULL_W-1:0] ext_a;
  logic signed [FULL_W-1:0] ext_b;
  logic [P_W-1:0]           prod_res;

  logic [P_W-1:0]   fin_p;
  logic [ID_W-1:0]  fin_id;
  logic             fin_v;

  logic [P_W-1:0]   mem_p  [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             fifo_full;

  // Credits cover in-flight plus queued results, so an issue can never overflow the FIFO.
  assign issue_ok = credit_cnt < DEPTH_C;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Gated by reset so the grant drops the instant reset asserts.
  always_comb begin
    req_ready = '0;
    if (ap_rst_n && issue_ok && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  assign issue = |(req_valid & req_ready);
  assign sel_a = req_a[int'(grant_idx)*A_W +: A_W];
  assign sel_b = req_b[int'(grant_idx)*B_W +: B_W];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr     <= '0;
      credit_cnt <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      s1_v       <= 1'b0;
    end else begin
      s1_v  <= issue;
      s1_a  <= sel_a;
      s1_b  <= sel_b;
      s1_id <= grant_idx;
      if (issue)
        rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
      unique case ({issue, pop})
        2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
        2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  assign ext_a = {{B_W{s1_a[A_W-1]}}, s1_a};
  assign ext_b = {{A_W{s1_b[B_W-1]}}, s1_b};

`ifdef EXAMPLE_MUL_SAT_EN
  localparam logic signed [FULL_W-1:0] SAT_MAX = {{(FULL_W-P_W+1){1'b0}}, {(P_W-1){1'b1}}};
  localparam logic signed [FULL_W-1:0] SAT_MIN = {{(FULL_W-P_W+1){1'b1}}, {(P_W-1){1'b0}}};
  logic signed [FULL_W-1:0] prod_full;

  assign prod_full = ext_a * ext_b;

  always_comb begin
    if (prod_full > SAT_MAX)
      prod_res = SAT_MAX[P_W-1:0];
    else if (prod_full < SAT_MIN)
      prod_res = SAT_MIN[P_W-1:0];
    else
      prod_res = prod_full[P_W-1:0];
  end
`else
  assign prod_res = P_W'(ext_a * ext_b);
`endif

  // Stage 1 holds operands; the remaining MUL_STAGES-1 registers carry the product.
  if (MUL_STAGES == 1) begin : g_direct
    assign fin_p  = prod_res;
    assign fin_id = s1_id;
    assign fin_v  = s1_v;
  end else begin : g_pipe
    logic [P_W-1:0]  pp  [MUL_STAGES-1];
    logic [ID_W-1:0] pid [MUL_STAGES-1];
    logic            pv  [MUL_STAGES-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < MUL_STAGES-1; i++) begin
          pp[i]  <= '0;
          pid[i] <= '0;
          pv[i]  <= 1'b0;
        end
      end else begin
        pp[0]  <= prod_res;
        pid[0] <= s1_id;
        pv[0]  <= s1_v;
        for (int i = 1; i < MUL_STAGES-1; i++) begin
          pp[i]  <= pp[i-1];
          pid[i] <= pid[i-1];
          pv[i]  <= pv[i-1];
        end
      end
    end

    assign fin_p  = pp[MUL_STAGES-2];
    assign fin_id = pid[MUL_STAGES-2];
    assign fin_v  = pv[MUL_STAGES-2];
  end

  always_ff @(posedge ap_clk) begin
    if (fin_v) begin
      mem_p[wr_ptr[PTR_W-1:0]]  <= fin_p;
      mem_id[wr_ptr[PTR_W-1:0]] <= fin_id;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fin_v)
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  assign fifo_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rsp_valid = (wr_ptr != rd_ptr);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_p     = rsp_valid ? mem_p[rd_ptr[PTR_W-1:0]]  : '0;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr[PTR_W-1:0]] : '0;
  assign busy      = (credit_cnt != '0);

  a_grant_onehot: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    $onehot0(req_ready));
  a_credit_bound: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    credit_cnt <= DEPTH_C);
  a_no_overflow:  assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(fin_v && fifo_full && !pop));

endmodule

// File: tb/tb_example_mul_share_arb.sv
// Directed self-checking bench for example_mul_share_arb with default parameters.
module tb_example_mul_share_arb;

  localparam int NUM_REQ = 4;
  localparam int A_W     = 12;
  localparam int B_W     = 14;
  localparam int P_W     = 21;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a = '0;
  logic [NUM_REQ*B_W-1:0] req_b = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [P_W-1:0]         rsp_p;
  logic [1:0]             rsp_id;
  logic                   busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 ap_clk = ~ap_clk;

  example_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  // Requester id's operands in the round-robin scenario: a=id+1, b=-(id+2)
  function automatic logic [P_W-1:0] rr_p(input int id);
    return P_W'(-((id + 1) * (id + 2)));
  endfunction

  task automatic test_reset();
    ap_rst_n  = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("[TB] FAIL reset_req_ready: got %0h expected 0", req_ready); end
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
    vec_cnt++; if (rsp_p !== '0) begin err_cnt++; $display("[TB] FAIL reset_rsp_p: got %0h expected 0", rsp_p); end
    vec_cnt++; if (rsp_id !== 2'd0) begin err_cnt++; $display("[TB] FAIL reset_rsp_id: got %0h expected 0", rsp_id); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    req_valid = '0;
    rsp_ready = 1'b0;
    ap_rst_n  = 1'b1;
  endtask

  task automatic test_single();
    @(negedge ap_clk);
    set_ops(2, 3, -5);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    vec_cnt++; if (req_ready !== 4'b0100) begin err_cnt++; $display("[TB] FAIL single_grant: got %0h expected 4", req_ready); end
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_early1: got %0h expected 0", rsp_valid); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_busy: got %0h expected 1", busy); end
    @(posedge ap_clk);
    @(negedge ap_clk);
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_early2: got %0h expected 0", rsp_valid); end
    @(posedge ap_clk);
    @(negedge ap_clk);
    vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_valid: got %0h expected 1", rsp_valid); end
    vec_cnt++; if (rsp_p !== P_W'(-15)) begin err_cnt++; $display("[TB] FAIL single_p: got %0h expected %0h", rsp_p, P_W'(-15)); end
    vec_cnt++; if (rsp_id !== 2'd2) begin err_cnt++; $display("[TB] FAIL single_id: got %0h expected 2", rsp_id); end
    @(posedge ap_clk);
    @(negedge ap_clk);
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_popped: got %0h expected 0", rsp_valid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_idle: got %0h expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int q[$];
    logic [NUM_REQ-1:0] exp_g;
    int id;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, i + 1, -(i + 2));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_g = NUM_REQ'(1 << (c % NUM_REQ));
      vec_cnt++; if (req_ready !== exp_g) begin err_cnt++; $display("[TB] FAIL rr_grant[%0d]: got %0h expected %0h", c, req_ready, exp_g); end
      if (c >= 3) begin
        vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("[TB] FAIL rr_stream_valid[%0d]: got %0h expected 1", c, rsp_valid); end
      end
      if (rsp_valid && q.size() > 0) begin
        id = q.pop_front();
        vec_cnt++; if (rsp_id !== 2'(id)) begin err_cnt++; $display("[TB] FAIL rr_id[%0d]: got %0h expected %0h", c, rsp_id, id); end
        vec_cnt++; if (rsp_p !== rr_p(id)) begin err_cnt++; $display("[TB] FAIL rr_p[%0d]: got %0h expected %0h", c, rsp_p, rr_p(id)); end
      end
      q.push_back(c % NUM_REQ);
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    req_valid = '0;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      #1;
      if (rsp_valid) begin
        id = q.pop_front();
        vec_cnt++; if (rsp_id !== 2'(id)) begin err_cnt++; $display("[TB] FAIL rr_drain_id: got %0h expected %0h", rsp_id, id); end
        vec_cnt++; if (rsp_p !== rr_p(id)) begin err_cnt++; $display("[TB] FAIL rr_drain_p: got %0h expected %0h", rsp_p, rr_p(id)); end
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    vec_cnt++; if (q.size() != 0) begin err_cnt++; $display("[TB] FAIL rr_drain_left: got %0d expected 0", q.size()); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL rr_idle: got %0h expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int n_issue;
    int n_pop;
    do_reset();
    set_ops(0, 5, 7);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    n_issue   = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready[0]) n_issue++;
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    #1;
    vec_cnt++; if (n_issue != 4) begin err_cnt++; $display("[TB] FAIL bp_issues: got %0d expected 4", n_issue); end
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("[TB] FAIL bp_stalled: got %0h expected 0", req_ready); end
    vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("[TB] FAIL bp_held_valid: got %0h expected 1", rsp_valid); end
    vec_cnt++; if (rsp_p !== P_W'(35)) begin err_cnt++; $display("[TB] FAIL bp_held_p: got %0h expected 23", rsp_p); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("[TB] FAIL bp_busy: got %0h expected 1", busy); end
    rsp_ready = 1'b1;
    #1;
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("[TB] FAIL bp_pop_cycle_grant: got %0h expected 0", req_ready); end
    @(posedge ap_clk);
    @(negedge ap_clk);
    #1;
    vec_cnt++; if (req_ready !== 4'b0001) begin err_cnt++; $display("[TB] FAIL bp_regrant: got %0h expected 1", req_ready); end
    req_valid = '0;
    n_pop = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (rsp_valid) begin
        n_pop++;
        vec_cnt++; if (rsp_p !== P_W'(35)) begin err_cnt++; $display("[TB] FAIL bp_drain_p: got %0h expected 23", rsp_p); end
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    vec_cnt++; if (n_pop != 3) begin err_cnt++; $display("[TB] FAIL bp_pops: got %0d expected 3", n_pop); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL bp_idle: got %0h expected 0", busy); end
  endtask

  task automatic test_corner();
    int ca[3] = '{2047, -2048, -2048};
    int cb[3] = '{8191, -8192, 8191};
    int ew[3] = '{-10239, 0, 2048};
    int es[3] = '{1048575, 1048575, -1048576};
    logic [P_W-1:0] exp_p;
    logic seen;
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
`ifdef EXAMPLE_MUL_SAT_EN
      exp_p = P_W'(es[t]);
`else
      exp_p = P_W'(ew[t]);
`endif
      @(negedge ap_clk);
      set_ops(1, ca[t], cb[t]);
      req_valid = 4'b0010;
      #1;
      vec_cnt++; if (req_ready !== 4'b0010) begin err_cnt++; $display("[TB] FAIL corner_grant[%0d]: got %0h expected 2", t, req_ready); end
      @(posedge ap_clk);
      @(negedge ap_clk);
      req_valid = '0;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        #1;
        if (rsp_valid) seen = 1'b1;
        else begin
          @(posedge ap_clk);
          @(negedge ap_clk);
        end
      end
      vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("[TB] FAIL corner_timeout[%0d]: got %0h expected 1", t, seen); end
      vec_cnt++; if (rsp_p !== exp_p) begin err_cnt++; $display("[TB] FAIL corner_p[%0d]: got %0h expected %0h", t, rsp_p, exp_p); end
      vec_cnt++; if (rsp_id !== 2'd1) begin err_cnt++; $display("[TB] FAIL corner_id[%0d]: got %0h expected 1", t, rsp_id); end
      @(posedge ap_clk);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_ops(0, 4, 4);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    repeat (3) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    req_valid = '0;
    #1;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("[TB] FAIL mid_busy_before: got %0h expected 1", busy); end
    vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("[TB] FAIL mid_valid_before: got %0h expected 1", rsp_valid); end
    req_valid = '1;
    ap_rst_n  = 1'b0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_rst_valid: got %0h expected 0", rsp_valid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_rst_busy: got %0h expected 0", busy); end
    vec_cnt++; if (rsp_p !== '0) begin err_cnt++; $display("[TB] FAIL mid_rst_p: got %0h expected 0", rsp_p); end
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("[TB] FAIL mid_rst_ready: got %0h expected 0", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    ap_rst_n  = 1'b1;
    repeat (3) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_after_busy: got %0h expected 0", busy); end
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_after_valid: got %0h expected 0", rsp_valid); end
    req_valid = '1;
    #1;
    vec_cnt++; if (req_ready !== 4'b0001) begin err_cnt++; $display("[TB] FAIL mid_after_priority: got %0h expected 1", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_corner();
    test_reset_midstream();
    repeat (2) @(posedge ap_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
